// File: rtl/pipe_muldiv_ctrl.sv
// rtl/pipe_muldiv_ctrl.sv - iterative multiply/divide sequencer owning HI/LO
//
// Purpose:
//   Sits beside ID/EXE. When ID decodes mult/multu/div/divu it latches the
//   forwarded operands and runs a one-bit-per-cycle shift-add multiply or
//   restoring divide. Results land in HI/LO. A stall is raised while an
//   mfhi/mflo or a new mult/div would observe an unfinished result.
//
// Optional feature (macro MULDIV_SIGNED_EN):
//   defined   - op[0] selects signed mode; magnitudes are computed at accept
//               and a one-cycle SIGN state fixes result signs (latency W+2).
//   undefined - all ops unsigned, no SIGN state (latency W+1).
//
// Ports:
//   clock    in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   start    in   ID decoded mult/multu/div/divu
//   op       in   00 multu, 01 mult, 10 divu, 11 div
//   opa/opb  in   forwarded rs/rt operands
//   rd_hilo  in   ID decoded mfhi/mflo
//   cancel   in   flush; aborts the operation in flight
//   hi/lo    out  HI/LO registers
//   busy     out  operation in flight (RUN/SIGN)
//   done     out  one-cycle pulse when HI/LO are updated
//   stall    out  freeze PC/IR request

module pipe_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             rd_hilo,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
`endif

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 div_q, div_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 accept;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;

`ifdef MULDIV_SIGNED_EN
  logic                 a_neg, b_neg;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   prod_neg;
  assign a_neg    = op[0] & opa[WIDTH-1];
  assign b_neg    = op[0] & opb[WIDTH-1];
  assign mag_a    = a_neg ? (~opa + 1'b1) : opa;
  assign mag_b    = b_neg ? (~opb + 1'b1) : opb;
  assign prod_neg = ~acc_q + 1'b1;
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign mag_a      = opa;
  assign mag_b      = opb;
`endif

  assign accept = (state_q == S_IDLE || state_q == S_DONE) && start && !cancel;

  // Shift-add step: the carry of the upper-half add shifts into the MSB.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring-divide step. rem_sh keeps the bit shifted out of the remainder
  // so the compare is exact; the low WIDTH bits of the difference suffice
  // because the true difference is below 2^WIDTH whenever it is kept.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_next = (rem_sh >= {1'b0, opnd_q})
                    ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                    : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = '0;
          div_d   = op[1];
          acc_d   = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          opnd_d  = op[1] ? mag_b : mag_a;
`ifdef MULDIV_SIGNED_EN
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
`endif
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          // All WIDTH iterations are in acc_q; this cycle publishes them.
`ifdef MULDIV_SIGNED_EN
          state_d = S_SIGN;
`else
          state_d = S_DONE;
          hi_d    = acc_q[2*WIDTH-1:WIDTH];
          lo_d    = acc_q[WIDTH-1:0];
`endif
        end else begin
          acc_d = div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_SIGN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (!div_q) begin
            {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
          end else begin
            // Divide by zero leaves the quotient all ones; the remainder
            // regains the dividend's sign, which restores opa exactly.
            lo_d = (neg_res_q && opnd_q != '0) ? prod_neg[WIDTH-1:0]
                                               : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                             : acc_q[2*WIDTH-1:WIDTH];
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

`ifdef MULDIV_SIGNED_EN
  assign busy = (state_q == S_RUN) || (state_q == S_SIGN);
`else
  assign busy = (state_q == S_RUN);
`endif
  assign done  = (state_q == S_DONE);
  assign stall = busy & (start | rd_hilo);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// tb/tb_pipe_muldiv_ctrl.sv - scoreboard bench for pipe_muldiv_ctrl

module tb_pipe_muldiv_ctrl;
  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clock, resetn, start, rd_hilo, cancel;
  logic [1:0]   op;
  logic [W-1:0] opa, opb, hi, lo;
  logic         busy, done, stall;

  logic [63:0]  sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  pipe_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op),
    .opa(opa), .opb(opb), .rd_hilo(rd_hilo), .cancel(cancel),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (resetn && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  // Called 1ns after a rising edge; returns 1ns after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    start = 1'b1; op = o; opa = a; opb = b;
    sb.push_back(exp);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, 64'(n), 64'(LAT));
    @(posedge clock); #1;
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion before %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    int cyc;
    resetn = 1'b0; start = 1'b0; rd_hilo = 1'b0; cancel = 1'b0;
    op = 2'b00; opa = '0; opb = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hi",    {32'd0, hi}, 64'd0);
    check("rst_lo",    {32'd0, lo}, 64'd0);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Directed results and latency.
    issue(2'b00, 32'd7, 32'd6, {32'd0, 32'h2A});
    wait_done("lat_multu_7x6");
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    wait_done("lat_multu_max");
    issue(2'b10, 32'd100, 32'd7, {32'd2, 32'd14});
    wait_done("lat_divu_100_7");
    issue(2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
    wait_done("lat_divu_by0");

    // Random unsigned ops against a behavioural model.
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      if (i % 2 == 1) begin
        b = $urandom_range(1, 32'hFFFF);
        issue(2'b10, a, b, {a % b, a / b});
      end else begin
        b = $urandom;
        issue(2'b00, a, b, 64'(a) * 64'(b));
      end
      wait_done("lat_random");
    end

    // Stall: mfhi at cycle 5, second start at cycle 10 held until DONE.
    issue(2'b00, 32'd3, 32'd4, {32'd0, 32'd12});
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      if (done) break;
      if (cyc == 5) begin
        rd_hilo = 1'b1; #1;
        check("stall_rd_hilo", {63'd0, stall}, 64'd1);
        rd_hilo = 1'b0; #1;
        check("stall_quiet", {63'd0, stall}, 64'd0);
      end
      if (cyc == 10) begin
        start = 1'b1; op = 2'b10; opa = 32'd50; opb = 32'd3;
        sb.push_back({32'd2, 32'd16});
      end
      if (cyc >= 10) begin
        #1;
        check("stall_start", {63'd0, stall}, 64'd1);
      end
    end
    check("lat_first_of_pair", 64'(cyc), 64'(LAT));
    check("stall_in_done", {63'd0, stall}, 64'd0);
    rd_hilo = 1'b1; #1;
    check("stall_rd_in_done", {63'd0, stall}, 64'd0);
    rd_hilo = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    check("second_accepted", {63'd0, busy}, 64'd1);
    wait_done("lat_second_of_pair");

    // Cancel a divu at cycle 12 after a multu left 0/0x2A.
    issue(2'b00, 32'd7, 32'd6, {32'd0, 32'h2A});
    wait_done("lat_pre_cancel");
    start = 1'b1; op = 2'b10; opa = 32'd1000; opb = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (11) begin @(posedge clock); #1; end
    cancel = 1'b1;
    @(posedge clock); #1;
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_hi", {32'd0, hi}, 64'd0);
    check("cancel_lo", {32'd0, lo}, 64'h2A);
    repeat (40) begin @(posedge clock); #1; end
    check("cancel_hold_lo", {32'd0, lo}, 64'h2A);

    // Cancel with start in IDLE: start dropped.
    start = 1'b1; cancel = 1'b1; op = 2'b00; opa = 32'd2; opb = 32'd2;
    @(posedge clock); #1;
    start = 1'b0; cancel = 1'b0;
    check("cancel_blocks_start", {63'd0, busy}, 64'd0);

`ifdef MULDIV_SIGNED_EN
    issue(2'b01, 32'hFFFFFFFD, 32'd5, {32'hFFFFFFFF, 32'hFFFFFFF1});
    wait_done("lat_mult_signed");
    issue(2'b11, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    wait_done("lat_div_signed");
`endif

    // Asynchronous reset mid-RUN.
    start = 1'b1; op = 2'b00; opa = 32'd9; opb = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    resetn = 1'b0; #1;
    check("arst_hi",    {32'd0, hi}, 64'd0);
    check("arst_lo",    {32'd0, lo}, 64'd0);
    check("arst_busy",  {63'd0, busy}, 64'd0);
    check("arst_done",  {63'd0, done}, 64'd0);
    check("arst_stall", {63'd0, stall}, 64'd0);
    #2 resetn = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check("arst_no_done_lo", {32'd0, lo}, 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
